// File: rtl/awg_param_ctrl.sv
// awg_param_ctrl: push-button front panel for an arbitrary waveform generator.
//
// Four raw active-low keys are synchronised, debounced and edge-detected into
// one-cycle press pulses. The pulses drive a small field-select FSM
// (FREQ -> AMP -> PHASE) and the registered generator parameters.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   key_sel      in   raw key, active-low: advance the selected field
//   key_up       in   raw key, active-low: increase the selected field
//   key_down     in   raw key, active-low: decrease the selected field
//   key_en       in   raw key, active-low: toggle en
//   en           out  generator enable
//   state_freq   out  [11:0] phase-accumulator step, saturating in 1..4095
//   state_amp    out  [2:0]  amplitude divisor, saturating in 1..7
//   state_phase  out  [7:0]  phase offset, wraps modulo 256
//   field_sel    out  [1:0]  0=FREQ, 1=AMP, 2=PHASE
module awg_param_ctrl #(
    parameter logic [19:0] DEB_CNT    = 20'd500000,
    parameter logic [11:0] FREQ_STEP  = 12'd16,
    parameter logic [7:0]  PHASE_STEP = 8'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_sel,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_en,
    output logic        en,
    output logic [11:0] state_freq,
    output logic [2:0]  state_amp,
    output logic [7:0]  state_phase,
    output logic [1:0]  field_sel
);

    localparam int unsigned NumKeys = 4;
    localparam int unsigned KSel    = 0;
    localparam int unsigned KUp     = 1;
    localparam int unsigned KDown   = 2;
    localparam int unsigned KEn     = 3;

    typedef enum logic [1:0] {
        StFreq  = 2'd0,
        StAmp   = 2'd1,
        StPhase = 2'd2
    } field_e;

    // ------------------------------------------------------------------
    // Key conditioning: 2-flop sync, debounce counter, press detect
    // ------------------------------------------------------------------
    logic [NumKeys-1:0] key_raw;
    logic [NumKeys-1:0] sync1_q, sync2_q;
    logic [NumKeys-1:0] deb_q, deb_d;
    logic [NumKeys-1:0] deb_prev_q;
    logic [NumKeys-1:0] press_q, press_d;
    logic [19:0]        cnt_q [NumKeys];
    logic [19:0]        cnt_d [NumKeys];

    assign key_raw = {key_en, key_down, key_up, key_sel};

    always_comb begin
        for (int k = 0; k < NumKeys; k++) begin
            deb_d[k] = deb_q[k];
            cnt_d[k] = '0;
            if (sync2_q[k] != deb_q[k]) begin
                if (cnt_q[k] == DEB_CNT - 20'd1) begin
                    deb_d[k] = sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 20'd1;
                end
            end
        end
        // Press = falling edge of the debounced level, seen one cycle late.
        press_d = deb_prev_q & ~deb_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            deb_q      <= '1;
            deb_prev_q <= '1;
            press_q    <= '0;
            for (int k = 0; k < NumKeys; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            sync1_q    <= key_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            press_q    <= press_d;
            for (int k = 0; k < NumKeys; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Field FSM and parameter registers
    // ------------------------------------------------------------------
    field_e      field_q, field_d;
    logic        en_q, en_d;
    logic [11:0] freq_q, freq_d;
    logic [2:0]  amp_q, amp_d;
    logic [7:0]  phase_q, phase_d;

    // 13-bit so carry-out / borrow are visible instead of wrapping.
    logic [12:0] freq_sum, freq_diff;
    logic        adj_up, adj_down;

    assign freq_sum  = {1'b0, freq_q} + {1'b0, FREQ_STEP};
    assign freq_diff = {1'b0, freq_q} - {1'b0, FREQ_STEP};

    // up+down together cancel; sel wins over any adjustment.
    assign adj_up   = press_q[KUp] & ~press_q[KDown] & ~press_q[KSel];
    assign adj_down = press_q[KDown] & ~press_q[KUp] & ~press_q[KSel];

    always_comb begin
        field_d = field_q;
        en_d    = en_q;
        freq_d  = freq_q;
        amp_d   = amp_q;
        phase_d = phase_q;

        if (press_q[KEn]) begin
            en_d = ~en_q;
        end

        if (press_q[KSel]) begin
            unique case (field_q)
                StFreq:  field_d = StAmp;
                StAmp:   field_d = StPhase;
                StPhase: field_d = StFreq;
                default: field_d = StFreq;
            endcase
        end else if (adj_up || adj_down) begin
            unique case (field_q)
                StFreq: begin
                    if (adj_up) begin
                        freq_d = freq_sum[12] ? 12'd4095 : freq_sum[11:0];
                    end else begin
                        freq_d = (freq_diff[12] || freq_diff[11:0] == 12'd0) ?
                                 12'd1 : freq_diff[11:0];
                    end
                end
                StAmp: begin
                    if (adj_up && amp_q != 3'd7) begin
                        amp_d = amp_q + 3'd1;
                    end else if (adj_down && amp_q > 3'd1) begin
                        amp_d = amp_q - 3'd1;
                    end
                end
                StPhase: begin
                    phase_d = adj_up ? phase_q + PHASE_STEP : phase_q - PHASE_STEP;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            field_q <= StFreq;
            en_q    <= 1'b0;
            freq_q  <= 12'd1;
            amp_q   <= 3'd1;
            phase_q <= 8'd0;
        end else begin
            field_q <= field_d;
            en_q    <= en_d;
            freq_q  <= freq_d;
            amp_q   <= amp_d;
            phase_q <= phase_d;
        end
    end

    assign en          = en_q;
    assign state_freq  = freq_q;
    assign state_amp   = amp_q;
    assign state_phase = phase_q;
    assign field_sel   = field_q;

endmodule

// File: doc/awg_param_ctrl.md
AWG_PARAM_CTRL -- requirements
Module: awg_param_ctrl

Interface
- REQ-001: Parameter DEB_CNT, default 20'd500000, is the number of consecutive stable cycles required to accept a key level change.
- REQ-002: Parameter FREQ_STEP, default 12'd16, is the state_freq increment/decrement per press.
- REQ-003: Parameter PHASE_STEP, default 8'd8, is the state_phase increment/decrement per press.
- REQ-004: clk  input  1  system clock; the only clock in the block.
- REQ-005: rst  input  1  reset; synchronous, active-high.
- REQ-006: key_sel  input  1  raw push-button, active-low, asynchronous; cycles the selected field.
- REQ-007: key_up  input  1  raw push-button, active-low, asynchronous; increases the selected field.
- REQ-008: key_down  input  1  raw push-button, active-low, asynchronous; decreases the selected field.
- REQ-009: key_en  input  1  raw push-button, active-low, asynchronous; toggles en.
- REQ-010: en  output  1  generator enable, registered.
- REQ-011: state_freq  output  12  phase-accumulator step for the downstream generator, registered.
- REQ-012: state_amp  output  3  amplitude divisor for the downstream generator, registered.
- REQ-013: state_phase  output  8  phase offset for the downstream generator, registered.
- REQ-014: field_sel  output  2  currently selected field: 0=FREQ, 1=AMP, 2=PHASE; registered.

Function
- REQ-015: Each key SHALL pass through a 2-flop synchronizer before any other logic.
- REQ-016: Each key SHALL have an independent debounce counter.
  - Counter increments while the synchronized level differs from the debounced level; it clears to 0 when they are equal.
  - When the counter reaches DEB_CNT-1 and the levels still differ, the debounced level SHALL take the synchronized value on the next edge and the counter SHALL clear.
- REQ-017: A press SHALL be a 1->0 transition of a debounced level. It generates a registered one-cycle press pulse in the cycle after the transition; release generates nothing.
- REQ-018: The selected field and every output SHALL update on the clock edge following a press pulse.
  - Total latency from the first raw-low sample to the output change = 2 + DEB_CNT + 2 cycles.
- REQ-019: Field FSM states are FREQ, AMP, PHASE; a key_sel press moves FREQ->AMP->PHASE->FREQ. field_sel SHALL encode the state as 0, 1, 2; value 3 is unreachable.
- REQ-020: FREQ field behaviour:
  - key_up: state_freq += FREQ_STEP, saturating at 12'd4095.
  - key_down: state_freq -= FREQ_STEP, saturating at 12'd1.
  - Computation SHALL use 13-bit arithmetic so overflow and underflow are detected, never wrapped.
- REQ-021: AMP field behaviour: key_up increments state_amp and key_down decrements it, saturating within 1..7; 0 SHALL never be output because the downstream stage divides by it.
- REQ-022: PHASE field behaviour: key_up adds PHASE_STEP and key_down subtracts PHASE_STEP, both wrapping modulo 256.
- REQ-023: A key_en press SHALL toggle en regardless of field_sel.
- REQ-024: Simultaneous key_up and key_down pulses in the same cycle SHALL leave all fields unchanged.
- REQ-025: A key_sel pulse coincident with key_up or key_down SHALL advance the FSM, and the adjustment in that cycle SHALL be discarded.
- REQ-026: A key_en pulse coincident with any other pulse SHALL toggle en, and the other pulse SHALL be processed as if it were alone.
- REQ-027: A key held down SHALL produce exactly one press; auto-repeat is not supported.
- REQ-028: Bounces shorter than DEB_CNT cycles SHALL produce no press and no release.

Reset
- REQ-029: While rst=1 on a clock edge, the block SHALL load:
  - en=0, state_freq=12'd1, state_amp=3'd1, state_phase=8'd0, field_sel=0 (FREQ);
  - all debounced levels=1 (released), all synchronizer flops=1, all counters=0, no press pulses.
- REQ-030: Reset asserted mid-debounce or mid-press SHALL discard the pending event. A key still held low at reset release SHALL register as a new press after the full latency of REQ-018.

Verification (DEB_CNT=4, FREQ_STEP=16, PHASE_STEP=8)
- REQ-031: After reset, hold key_up low for 20 cycles -> state_freq goes 1->17 exactly 8 cycles after the first low sample; no further change while held or on release.
- REQ-032: Toggle key_up low/high every 2 cycles for 40 cycles, then leave it high -> state_freq stays 1 and no press pulse occurs.
- REQ-033: Two key_sel presses, then 40 key_up presses -> field_sel=2, state_phase=8'd64 (wrapped past 255 once); a key_down press from 0 -> 8'd248.
- REQ-034: In the AMP field, 10 key_down presses -> state_amp=1; then 10 key_up presses -> state_amp=7.
- REQ-035: Press key_up and key_down on identical raw cycles in FREQ with state_freq=1 -> state_freq stays 1. Press key_sel and key_up together -> field_sel=1 and state_freq stays unchanged.
- REQ-036: With en=1 and state_freq=12'd4081, press key_up twice -> state_freq 4081->4095->4095. Assert rst for 1 cycle -> en=0, state_freq=1, field_sel=0 on the next edge.
